imm_decode_pipe: RTL
====================

Name: imm_decode_pipe

Overview:
- Registered, flow-controlled immediate-decode stage.
- Generalises the single-cycle combinational immGen:
  - XLEN parameter (32/64).
  - Format classification and illegal-opcode detection.
  - Shift-amount immediates.
  - PC-relative target computation.
  - valid/ready handshake with a one-entry skid buffer.
- Sits between fetch and register-read in the pipelined core.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets immediate sign-extension width and the RV64 opcode set.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept this cycle
- in_inst  input  32  instruction word
- in_pc  input  XLEN  PC of in_inst
- out_valid  output  1  decoded result valid
- out_ready  input  1  downstream accepts
- out_imm  output  XLEN  decoded immediate
- out_fmt  output  3  format code (see package)
- out_target  output  XLEN  out_pc + out_imm for B/J/AUIPC, else 0
- out_pc  output  XLEN  PC passed through
- out_illegal  output  1  unsupported opcode or inst[1:0] != 2'b11

Behaviour:
- Reset: one clock, reset is synchronous and active-high.
  - While rst=1: in_ready=0.
  - First edge with rst=1: out_valid=0, skid empty, out_imm/out_target/out_pc=0, out_fmt=FMT_NONE, out_illegal=0.
  - Reset mid-transfer discards both held entries; no partial output.
- Transfers:
  - Input transfer: in_valid & in_ready at posedge.
  - Output transfer: out_valid & out_ready at posedge.
  - Latency: 1 cycle from input transfer to out_valid when the output register is empty or draining.
- Formats (opcode = inst[6:0]):
  - FMT_I: 0000011, 0010011, 1100111, 1110011, 0001111. Imm = sign-ext inst[31:20].
  - FMT_S: 0100011. Imm = sign-ext {inst[31:25], inst[11:7]}.
  - FMT_B: 1100011. Imm = sign-ext {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - FMT_U: 0110111, 0010111. Imm = sign-ext {inst[31:12], 12'b0}.
  - FMT_J: 1101111. Imm = sign-ext {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - FMT_NONE: 0110011. Imm = 0, not illegal.
  - XLEN=64 only:
    - 0011011 is FMT_I.
    - 0111011 is FMT_NONE.
    - 0000011 and 0100011 are unchanged.
  - XLEN=32: 0011011 and 0111011 are illegal.
- Shift immediates:
  - Opcode 0010011 with funct3 001/101: imm = zero-ext inst[24:20] (XLEN=32) or inst[25:20] (XLEN=64). Format stays FMT_I.
  - Opcode 0011011 with funct3 001/101: imm = zero-ext inst[24:20].
- Illegal: any other opcode, or inst[1:0] != 11. Then out_illegal=1, imm=0, target=0, fmt=FMT_NONE.
  - The entry still flows normally; it is never dropped.
- Target:
  - out_pc + out_imm, modulo 2^XLEN, for FMT_B, FMT_J, and opcode 0010111.
  - 0 otherwise, including JALR.
- Skid buffer:
  - in_ready = !rst & !skid_valid, driven from a register. No combinational path from out_ready to in_ready.
  - Input transfer while the output register is full and not draining: decoded entry goes to skid.
  - Output transfer while skid is full: skid moves to the output register.
  - Output transfer, skid empty, simultaneous input transfer: new entry goes to the output register.
  - Order is strictly FIFO. Output fields stay stable while out_valid & !out_ready.
- Throughput: 1 instruction/cycle with out_ready held high.

Decomposition:
- Shared package imm_pkg holds:
  - Opcode constants: OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OPIMM32, OPC_OP32.
  - Format codes: FMT_NONE=0, FMT_I=1, FMT_S=2, FMT_B=3, FMT_U=4, FMT_J=5.
- Sub-module imm_decode_comb, parametrised by XLEN: purely combinational decode of inst/pc to imm/fmt/illegal/target.
- The top level holds only the output register, skid register and handshake.

Test Plan:
- XLEN=32, addi x1,x2,-12 (0xFF410093), pc=0x100 -> next cycle: out_imm=0xFFFFFFF4, fmt=FMT_I, target=0, illegal=0.
- XLEN=32, beq -4 (0xFE208EE3), pc=0x100 -> imm=0xFFFFFFFC, fmt=FMT_B, target=0x000000FC. Same bench with lui 0x12345 (0x123450B7) -> imm=0x12345000, fmt=FMT_U.
- XLEN=64:
  - addi -12 -> imm=0xFFFFFFFFFFFFFFF4.
  - slli x1,x1,33 (0x02109093) -> imm=33.
  - lui 0x80000 (0x800000B7) -> imm=0xFFFFFFFF80000000.
  - XLEN=32 build with opcode 0011011 -> illegal=1.
- Backpressure: out_ready=0, three back-to-back in_valid instructions -> first two accepted, in_ready=0 on the cycle after the second. Then out_ready=1 -> three outputs in order, one per cycle, no loss or duplicate.
- inst=0x00000000 -> out_illegal=1, imm=0, fmt=FMT_NONE, out_valid asserted normally.
- Reset while output and skid are both full -> next cycle out_valid=0, in_ready=0 during rst. First post-reset instruction emerges one cycle after acceptance.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared opcode and format constants for the immediate-decode stage.
// Imported by imm_decode_comb and imm_decode_pipe.
package imm_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_FENCE    = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OPC_OP32     = 7'b0111011;

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational decode of inst/pc into imm, fmt, illegal, target.
// Ports: inst, pc in; imm, fmt, illegal, target out.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal,
  output logic [XLEN-1:0] target
);

  localparam bit RV64 = (XLEN == 64);

  logic [6:0]      opc;
  logic            shift;
  logic            rel;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] sh5;
  logic [XLEN-1:0] sh6;

  assign opc   = inst[6:0];
  // funct3 001 (sll) and 101 (srl/sra)
  assign shift = (inst[13:12] == 2'b01);

  assign imm_i = XLEN'($signed(inst[31:20]));
  assign imm_s = XLEN'($signed({inst[31:25], inst[11:7]}));
  assign imm_b = XLEN'($signed({inst[31], inst[7],
                                inst[30:25], inst[11:8],
                                1'b0}));
  assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({inst[31], inst[19:12],
                                inst[20], inst[30:21],
                                1'b0}));
  assign sh5   = XLEN'(inst[24:20]);
  assign sh6   = XLEN'(inst[25:20]);

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    rel     = 1'b0;
    unique case (opc)
      OPC_OPIMM: begin
        fmt = FMT_I;
        if (shift) imm = RV64 ? sh6 : sh5;
        else       imm = imm_i;
      end
      OPC_OPIMM32: begin
        if (RV64) begin
          fmt = FMT_I;
          imm = shift ? sh5 : imm_i;
        end else begin
          illegal = 1'b1;
        end
      end
      OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_FENCE: begin
        fmt = FMT_I;
        imm = imm_i;
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = imm_s;
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = imm_b;
        rel = 1'b1;
      end
      OPC_LUI: begin
        fmt = FMT_U;
        imm = imm_u;
      end
      OPC_AUIPC: begin
        fmt = FMT_U;
        imm = imm_u;
        rel = 1'b1;
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = imm_j;
        rel = 1'b1;
      end
      OPC_OP: begin
        fmt = FMT_NONE;
      end
      OPC_OP32: begin
        if (!RV64) illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    // compressed encodings are not supported
    if (inst[1:0] != 2'b11) begin
      imm     = '0;
      fmt     = FMT_NONE;
      illegal = 1'b1;
      rel     = 1'b0;
    end
  end

  assign target = rel ? pc + imm : '0;

endmodule

// File: rtl/imm_decode_pipe.sv
// Registered immediate-decode stage with valid/ready and 1-entry skid.
// Ports: clk, rst, in_* (inst, pc handshake), out_* (decoded result).
module imm_decode_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } ent_t;

  ent_t dec;
  ent_t out_q;
  ent_t skid_q;
  logic out_v;
  logic skid_v;
  logic in_fire;
  logic out_fire;

  imm_decode_comb #(
    .XLEN(XLEN)
  ) u_dec (
    .inst   (in_inst),
    .pc     (in_pc),
    .imm    (dec.imm),
    .fmt    (dec.fmt),
    .illegal(dec.illegal),
    .target (dec.target)
  );

  assign dec.pc   = in_pc;

  // ready depends only on registered skid state, never on out_ready
  assign in_ready = !rst && !skid_v;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_v && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else if (out_fire || !out_v) begin
      // skid can only be full while out_v, and blocks input
      if (skid_v) begin
        out_q  <= skid_q;
        out_v  <= 1'b1;
        skid_v <= 1'b0;
      end else if (in_fire) begin
        out_q <= dec;
        out_v <= 1'b1;
      end else begin
        out_v <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q <= dec;
      skid_v <= 1'b1;
    end
  end

  assign out_valid   = out_v;
  assign out_imm     = out_q.imm;
  assign out_fmt     = out_q.fmt;
  assign out_target  = out_q.target;
  assign out_pc      = out_q.pc;
  assign out_illegal = out_q.illegal;

endmodule
